lfsr_gen: RTL and testbench

- Parametrised linear-feedback shift register: the next generation of the team's fixed 4-bit LFSR.
- Adds the following over the fixed 4-bit version:
  - configurable width and polynomial
  - Fibonacci or Galois form
  - step enable and runtime seed load
  - zero-state protection
  - period measurement
- Used as a pseudo-random pattern source and scrambler seed generator in test and datapath blocks.

---
 rtl/lfsr_gen.sv | 96 +++++++++
 tb/tb_lfsr_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with step enable, seed load, zero-load
// protection and period measurement against the most recent reference seed.
module lfsr_gen #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]      SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned           MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             serial_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period_len,
  output logic             period_pulse,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] plen_q, plen_d;
  logic             pulse_q, pulse_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = '0;
    if (MODE == 0) begin
      nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end else begin
      nxt = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? TAPS : '0);
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    pulse_d = 1'b0;
    lock_d  = 1'b0;
    if (load) begin
      // An all-zero seed would lock the register; fall back to SEED and flag it.
      cnt_d = '0;
      if (seed_in != '0) begin
        state_d = seed_in;
        ref_d   = seed_in;
      end else begin
        state_d = SEED;
        ref_d   = SEED;
        lock_d  = 1'b1;
      end
    end else if (en) begin
      state_d = nxt;
      if (nxt == ref_q) begin
        cnt_d   = '0;
        plen_d  = cnt_q + ONE;
        pulse_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      plen_q  <= '0;
      pulse_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      pulse_q <= pulse_d;
      lock_q  <= lock_d;
    end
  end

  assign state        = state_q;
  assign serial_out   = state_q[WIDTH-1];
  assign step_cnt     = cnt_q;
  assign period_len   = plen_q;
  assign period_pulse = pulse_q;
  assign lockup       = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench: a 4-bit Fibonacci and a 4-bit Galois instance share stimulus;
// the driver queues expected results and a monitor checks them after each edge.
module tb_lfsr_gen;

  logic       clk;
  logic       rst, en, load;
  logic [3:0] seed_in;

  logic [3:0] f_state, f_cnt, f_plen;
  logic       f_ser, f_pulse, f_lock;
  logic [3:0] g_state, g_cnt, g_plen;
  logic       g_ser, g_pulse, g_lock;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .MODE(0)) u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state(f_state), .serial_out(f_ser), .step_cnt(f_cnt),
    .period_len(f_plen), .period_pulse(f_pulse), .lockup(f_lock)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'b0001), .MODE(1)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state(g_state), .serial_out(g_ser), .step_cnt(g_cnt),
    .period_len(g_plen), .period_pulse(g_pulse), .lockup(g_lock)
  );

  typedef struct {
    bit         sel;  // 0 = Fibonacci instance, 1 = Galois instance
    logic [3:0] st;
    logic [3:0] cnt;
    logic [3:0] plen;
    logic       pulse;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] fib_seq [15] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
                               4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
                               4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] gal_seq [15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                               4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111,
                               4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
  logic [3:0] ld_seq  [15] = '{4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.sel) begin
        chk("fib.state", f_state, e.st);
        chk("fib.serial_out", f_ser, e.st[3]);
        chk("fib.step_cnt", f_cnt, e.cnt);
        chk("fib.period_len", f_plen, e.plen);
        chk("fib.period_pulse", f_pulse, e.pulse);
        chk("fib.lockup", f_lock, e.lock);
      end else begin
        chk("gal.state", g_state, e.st);
        chk("gal.serial_out", g_ser, e.st[3]);
        chk("gal.step_cnt", g_cnt, e.cnt);
        chk("gal.period_len", g_plen, e.plen);
        chk("gal.period_pulse", g_pulse, e.pulse);
        chk("gal.lockup", g_lock, e.lock);
      end
    end
  end

  task automatic drive(input logic r, input logic l, input logic e, input logic [3:0] sd);
    @(negedge clk);
    rst = r; load = l; en = e; seed_in = sd;
  endtask

  task automatic push(input bit sel, input logic [3:0] st, input logic [3:0] cnt,
                      input logic [3:0] plen, input logic pulse, input logic lock);
    exp_t e;
    e.sel = sel; e.st = st; e.cnt = cnt; e.plen = plen; e.pulse = pulse; e.lock = lock;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; seed_in = '0;

    // Reset state of both instances
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      push(0, 4'b0001, 4'd0, 4'd0, 1'b0, 1'b0);
      push(1, 4'b0001, 4'd0, 4'd0, 1'b0, 1'b0);
    end

    // Full periods, Fibonacci and Galois side by side
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      push(0, fib_seq[i], (i == 14) ? 4'd0 : 4'(i + 1), (i == 14) ? 4'd15 : 4'd0, i == 14, 1'b0);
      push(1, gal_seq[i], (i == 14) ? 4'd0 : 4'(i + 1), (i == 14) ? 4'd15 : 4'd0, i == 14, 1'b0);
    end

    // Enable gating from 0001: en = 1,0,0,1
    drive(1'b0, 1'b0, 1'b1, 4'b0000); push(0, 4'b0011, 4'd1, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000); push(0, 4'b0011, 4'd1, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000); push(0, 4'b0011, 4'd1, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b0000); push(0, 4'b0111, 4'd2, 4'd15, 1'b0, 1'b0);

    // Load 1010 together with en: load wins, then a full period back to 1010
    drive(1'b0, 1'b1, 1'b1, 4'b1010); push(0, 4'b1010, 4'd0, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      push(0, ld_seq[i], (i == 14) ? 4'd0 : 4'(i + 1), 4'd15, i == 14, 1'b0);
    end

    // Zero-load protection, then one step and a hold
    drive(1'b0, 1'b1, 1'b0, 4'b0000); push(0, 4'b0001, 4'd0, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'b0000); push(0, 4'b0011, 4'd1, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000); push(0, 4'b0011, 4'd1, 4'd15, 1'b0, 1'b0);

    // Six more steps reach 0101 (seven since seed), then reset with load and en
    for (int i = 1; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b0000);
      push(0, fib_seq[i], 4'(i + 1), 4'd15, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 4'b1010); push(0, 4'b0001, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000); push(0, 4'b0001, 4'd0, 4'd0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("scoreboard.drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
